dial_move_parser: RTL and testbench
===================================

Name: dial_move_parser

Overview:
- Front end for dial_solver.
- Consumes the raw puzzle input as an ASCII byte stream (lines such as "L68\n", "R48\n").
- Emits one 16-bit move word per line on the same valid/ready interface that dial_solver accepts (val/valid/ready).
- Provides the transmit side of the move protocol: bit 15 is direction (1 = R/increment, 0 = L/decrement) and bits 14:0 are the unsigned click count.

Parameters:
- CNT_W, 15, width of the click-count field (val = {dir, count}).
- MOVES_W, 32, width of the emitted-move counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_data  in  8  ASCII input byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  parser accepts the byte this cycle.
- in_last  in  1  qualifies the final byte of the stream.
- val  out  CNT_W+1  move word {dir, count}.
- valid  out  1  move word valid.
- ready  in  1  consumer (dial_solver) accepts the move.
- last  out  1  qualifies the final move word.
- done  out  1  stream fully consumed and the last move delivered; sticky.
- err_syntax  out  1  sticky: malformed byte or line seen.
- err_overflow  out  1  sticky: count exceeded 2^CNT_W-1.
- moves_count  out  MOVES_W  number of completed move handshakes.

Behaviour:
- Clock and reset:
  - Single clock; synchronous active-low reset only.
  - Reset values: in_ready=0 during reset, valid=0, val=0, last=0, done=0, both err flags=0, moves_count=0, FSM=IDLE, accumulator=0.
  - Reset mid-move discards any partial line or pending word with no handshake.
- Byte transfer: occurs when in_valid && in_ready. Move transfer occurs when valid && ready.
- FSM:
  - IDLE:
    - in_ready=1.
    - 'L'/'R' latches dir (L=0, R=1), clears the accumulator and digit count, then goes to DIGITS.
    - CR, LF, space and ',' are skipped.
    - Any other byte sets err_syntax and is dropped.
    - in_last on any accepted byte in IDLE goes to FIN.
  - DIGITS:
    - in_ready=1.
    - On '0'-'9': acc = acc*10 + digit, saturating at 2^CNT_W-1; saturation sets err_overflow.
    - A terminator (CR/LF/space/',') with at least one digit loads val={dir, acc} and goes to EMIT.
    - A terminator with zero digits sets err_syntax, discards the move and goes to IDLE.
    - Any other non-digit byte sets err_syntax, discards the move and goes to IDLE.
    - in_last on a digit byte completes the move immediately (the digit is included) and goes to EMIT with last=1.
    - in_last on a terminator with at least one digit goes to EMIT with last=1.
    - in_last on a terminator with zero digits, or on any other non-digit byte, goes to FIN (err_syntax as above).
  - EMIT:
    - in_ready=0; valid=1.
    - val and last are held stable until ready.
    - On handshake: moves_count++, valid drops next cycle. Go to FIN if last, else IDLE.
  - FIN:
    - done=1, in_ready=0, valid=0. The state is terminal until reset.
- Latency and throughput:
  - valid rises the cycle after the terminating byte is accepted.
  - Minimum one cycle per byte; one extra cycle per line for the handshake (no overlap of EMIT with input).
- Handshake rules:
  - valid never deasserts without a handshake.
  - val does not change while valid=1.
  - ready may be held high permanently; ready low stalls the input through in_ready=0.
- Arithmetic:
  - Uses a CNT_W+4-bit intermediate for acc*10+digit, compared against 2^CNT_W-1 before commit.
  - Leading zeros are allowed ("R007" -> 7).
  - The count 0 ("R0\n") is legal and emitted.
- moves_count wraps modulo 2^MOVES_W.
- Err flags never clear except on reset. Parsing continues after an error.

Decomposition:
- Package dial_pkg:
  - typedef packed struct move_t {logic dir; logic [CNT_W-1:0] count;}.
  - DIR_R=1'b1, DIR_L=1'b0.
  - ASCII constants for 'L', 'R', '0', '9', CR, LF, space, ','.
  - FSM state enum {IDLE, DIGITS, EMIT, FIN}.
- dial_solver also uses move_t.
- One sub-module: dec_accum. It holds the digit accumulator, does the saturating multiply-by-10-add, and provides a clear input and an overflow output.

Test Plan:
1. Bytes "L68\n" with ready=1. Expect val=16'h0044, valid for 1 cycle, moves_count=1, no errors.
2. Bytes "R48\nL5\n" with ready held 0 for 5 cycles after the first valid. Expect val=16'h8030 stable while stalled, in_ready=0 during the stall, then val=16'h0005; moves_count=2.
3. Bytes "R99999\n". Expect val=16'hFFFF (count saturated to 32767) and err_overflow=1.
4. Bytes "X\nR\nR5\n". Expect err_syntax=1 and exactly one move, val=16'h8005.
5. Bytes "L1" with in_last on '1'. Expect val=16'h0001 with last=1; done=1 the cycle after the handshake; in_ready stays 0 afterwards.
6. rst_n=0 asserted while in EMIT (val=16'h8030 pending). Expect valid=0 after the reset edge, moves_count=0, and the next "R2\n" yields val=16'h8002.

Source files
------------

// File: rtl/dial_pkg.sv
// Shared types and constants for the dial move protocol.
// Used by dial_move_parser and dial_solver.
package dial_pkg;

   localparam int MOVE_CNT_W = 15;
   localparam int MOVE_CNT_DEF_W = 32;

   typedef struct packed {
      logic                  dir;
      logic [MOVE_CNT_W-1:0] count;
   } move_t;

   localparam logic DIR_R = 1'b1;
   localparam logic DIR_L = 1'b0;

   localparam logic [7:0] ASCII_L     = 8'h4C;
   localparam logic [7:0] ASCII_R     = 8'h52;
   localparam logic [7:0] ASCII_0     = 8'h30;
   localparam logic [7:0] ASCII_9     = 8'h39;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_SP    = 8'h20;
   localparam logic [7:0] ASCII_COMMA = 8'h2C;

   typedef enum logic [1:0] {IDLE, DIGITS, EMIT, FIN} state_t;

   function automatic logic is_term(input logic [7:0] b);
      return (b == ASCII_CR) || (b == ASCII_LF) || (b == ASCII_SP) || (b == ASCII_COMMA);
   endfunction

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= ASCII_0) && (b <= ASCII_9);
   endfunction

endpackage

// File: rtl/dial_move_parser_dec_accum.sv
// Saturating decimal accumulator: acc = acc*10 + digit, clamped to 2^CNT_W-1.
// acc_nxt already includes the digit being presented this cycle.
module dec_accum #(
   parameter int CNT_W = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             digit_en,
   input  logic [3:0]       digit,
   output logic [CNT_W-1:0] acc_nxt,
   output logic             ovf
);

   localparam int EXT_W = CNT_W + 4;
   localparam logic [EXT_W-1:0] MAX_EXT = {4'b0000, {CNT_W{1'b1}}};

   logic [CNT_W-1:0] acc_q;
   logic [EXT_W-1:0] prod;

   assign prod = ({4'b0000, acc_q} * EXT_W'(10)) + {{(EXT_W-4){1'b0}}, digit};
   assign ovf  = digit_en && (prod > MAX_EXT);

   always_comb begin
      acc_nxt = acc_q;
      if (digit_en) begin
         acc_nxt = ovf ? {CNT_W{1'b1}} : prod[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else if (clr) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_nxt;
      end
   end

endmodule

// File: rtl/dial_move_parser.sv
// ASCII "L68\n"-style line parser producing {dir, count} move words
// on a valid/ready interface; input is stalled while a word is pending.
module dial_move_parser
   import dial_pkg::*;
#(
   parameter int CNT_W   = 15,
   parameter int MOVES_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [7:0]         in_data,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_last,
   output logic [CNT_W:0]     val,
   output logic               valid,
   input  logic               ready,
   output logic               last,
   output logic               done,
   output logic               err_syntax,
   output logic               err_overflow,
   output logic [MOVES_W-1:0] moves_count
);

   state_t state_q, state_d;
   logic             dir_q, have_digit_q, last_q;
   logic [CNT_W:0]   val_q;
   logic             err_syntax_q, err_overflow_q;
   logic [MOVES_W-1:0] moves_q;

   logic b_xfer, b_digit, b_term, b_lr;
   logic acc_clr, acc_en, acc_ovf, load_word, syn_err;
   logic [CNT_W-1:0] acc_nxt;

   assign b_xfer  = in_valid && in_ready;
   assign b_digit = is_digit(in_data);
   assign b_term  = is_term(in_data);
   assign b_lr    = (in_data == ASCII_L) || (in_data == ASCII_R);

   assign acc_clr   = (state_q == IDLE) && b_xfer && b_lr;
   assign acc_en    = (state_q == DIGITS) && b_xfer && b_digit;
   // A digit carrying in_last closes the line with that digit included.
   assign load_word = (state_q == DIGITS) && b_xfer &&
                      ((b_digit && in_last) || (b_term && have_digit_q));
   assign syn_err   = b_xfer && (((state_q == IDLE) && !b_lr && !b_term) ||
                      ((state_q == DIGITS) && !b_digit && !(b_term && have_digit_q)));

   dec_accum #(.CNT_W(CNT_W)) u_accum (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (acc_clr),
      .digit_en (acc_en),
      .digit    (in_data[3:0]),
      .acc_nxt  (acc_nxt),
      .ovf      (acc_ovf)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (b_xfer) begin
               if (in_last)   state_d = FIN;
               else if (b_lr) state_d = DIGITS;
            end
         end
         DIGITS: begin
            if (b_xfer) begin
               if (load_word)    state_d = EMIT;
               else if (b_digit) state_d = DIGITS;
               else              state_d = in_last ? FIN : IDLE;
            end
         end
         EMIT: begin
            if (ready) state_d = last_q ? FIN : IDLE;
         end
         default: state_d = FIN;
      endcase
   end

   always_comb begin
      in_ready = rst_n && ((state_q == IDLE) || (state_q == DIGITS));
      valid    = (state_q == EMIT);
      done     = (state_q == FIN);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dir_q          <= DIR_L;
         have_digit_q   <= 1'b0;
         val_q          <= '0;
         last_q         <= 1'b0;
         err_syntax_q   <= 1'b0;
         err_overflow_q <= 1'b0;
         moves_q        <= '0;
      end else begin
         if (acc_clr) begin
            dir_q        <= (in_data == ASCII_R) ? DIR_R : DIR_L;
            have_digit_q <= 1'b0;
         end else if (acc_en) begin
            have_digit_q <= 1'b1;
         end
         if (load_word) begin
            val_q  <= {dir_q, acc_nxt};
            last_q <= in_last;
         end
         if (syn_err) err_syntax_q <= 1'b1;
         if (acc_ovf) err_overflow_q <= 1'b1;
         if ((state_q == EMIT) && ready) moves_q <= moves_q + 1'b1;
      end
   end

   assign val          = val_q;
   assign last         = last_q;
   assign err_syntax   = err_syntax_q;
   assign err_overflow = err_overflow_q;
   assign moves_count  = moves_q;

endmodule

// File: tb/tb_dial_move_parser.sv
// Directed bench for dial_move_parser: stimulus pushes expected move words,
// an independent monitor pops and compares them on every move handshake.
module tb_dial_move_parser;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_last = 1'b0;
   logic [15:0] val;
   logic        valid;
   logic        ready = 1'b1;
   logic        last;
   logic        done;
   logic        err_syntax;
   logic        err_overflow;
   logic [31:0] moves_count;

   int checks = 0;
   int failures = 0;
   int valid_cycles = 0;
   logic [16:0] exp_q[$];

   dial_move_parser #(.CNT_W(15), .MOVES_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_last      (in_last),
      .val          (val),
      .valid        (valid),
      .ready        (ready),
      .last         (last),
      .done         (done),
      .err_syntax   (err_syntax),
      .err_overflow (err_overflow),
      .moves_count  (moves_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compares every move handshake against the scoreboard.
   initial begin
      logic [16:0] e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && valid === 1'b1) begin
            valid_cycles++;
            if (ready === 1'b1) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_move", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  $display("move val=%h last=%0d", val, last);
                  chk("move_val", {16'h0, val}, {16'h0, e[16:1]});
                  chk("move_last", {31'h0, last}, {31'h0, e[0]});
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic send_byte(input byte b, input bit l);
      int n = 0;
      in_data  = b;
      in_valid = 1'b1;
      in_last  = l;
      forever begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            @(posedge clk);
            #1;
            break;
         end
         n++;
         if (n > 200) begin
            chk("in_ready_timeout", 32'd0, 32'd1);
            break;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_str(input string s, input bit last_on_final);
      for (int i = 0; i < s.len(); i++) begin
         send_byte(s[i], last_on_final && (i == s.len() - 1));
      end
   endtask

   task automatic wait_valid();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (valid !== 1'b1 && n < 200);
      chk("valid_seen", {31'h0, valid}, 32'd1);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain", exp_q.size(), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      valid_cycles = 0;
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      chk("rst_in_ready", {31'h0, in_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("rst_valid", {31'h0, valid}, 32'd0);
      chk("rst_val", {16'h0, val}, 32'd0);
      chk("rst_last", {31'h0, last}, 32'd0);
      chk("rst_done", {31'h0, done}, 32'd0);
      chk("rst_errs", {30'h0, err_syntax, err_overflow}, 32'd0);
      chk("rst_moves", moves_count, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      valid_cycles = 0;

      // 1: simple L move
      ready = 1'b1;
      exp_q.push_back({16'h0044, 1'b0});
      send_str("L68\n", 1'b0);
      drain();
      chk("t1_valid_cycles", valid_cycles, 32'd1);
      chk("t1_moves", moves_count, 32'd1);
      chk("t1_errs", {30'h0, err_syntax, err_overflow}, 32'd0);

      // 2: consumer stall
      do_reset();
      ready = 1'b0;
      exp_q.push_back({16'h8030, 1'b0});
      exp_q.push_back({16'h0005, 1'b0});
      fork
         send_str("R48\nL5\n", 1'b0);
         begin
            wait_valid();
            repeat (5) begin
               @(negedge clk);
               chk("t2_stall_in_ready", {31'h0, in_ready}, 32'd0);
               chk("t2_stall_val", {16'h0, val}, 32'h8030);
               chk("t2_stall_valid", {31'h0, valid}, 32'd1);
            end
            @(posedge clk);
            #1;
            ready = 1'b1;
         end
      join
      drain();
      chk("t2_moves", moves_count, 32'd2);

      // 3: saturation
      do_reset();
      exp_q.push_back({16'hFFFF, 1'b0});
      send_str("R99999\n", 1'b0);
      drain();
      chk("t3_overflow", {31'h0, err_overflow}, 32'd1);
      chk("t3_syntax", {31'h0, err_syntax}, 32'd0);

      // 4: syntax errors, parsing continues
      do_reset();
      exp_q.push_back({16'h8005, 1'b0});
      send_str("X\nR\nR5\n", 1'b0);
      drain();
      chk("t4_syntax", {31'h0, err_syntax}, 32'd1);
      chk("t4_moves", moves_count, 32'd1);
      chk("t4_overflow", {31'h0, err_overflow}, 32'd0);

      // 5: in_last on a digit
      do_reset();
      exp_q.push_back({16'h0001, 1'b1});
      send_str("L1", 1'b1);
      wait_valid();
      chk("t5_done_before", {31'h0, done}, 32'd0);
      @(negedge clk);
      chk("t5_done", {31'h0, done}, 32'd1);
      chk("t5_moves", moves_count, 32'd1);
      repeat (3) begin
         @(negedge clk);
         chk("t5_in_ready", {31'h0, in_ready}, 32'd0);
         chk("t5_valid", {31'h0, valid}, 32'd0);
      end
      drain();

      // 6: reset while a word is pending
      do_reset();
      ready = 1'b0;
      send_str("R48\n", 1'b0);
      wait_valid();
      chk("t6_pending_val", {16'h0, val}, 32'h8030);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("t6_rst_valid", {31'h0, valid}, 32'd0);
      chk("t6_rst_moves", moves_count, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      ready = 1'b1;
      exp_q.push_back({16'h8002, 1'b0});
      send_str("R2\n", 1'b0);
      drain();
      chk("t6_moves", moves_count, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
